// File: rtl/multi_digit_bcd_counter.sv
`default_nettype none
// ============================================================================
//  Module   : multi_digit_bcd_counter
//  Purpose  : N-digit BCD up/down counter for a seven-segment display path.
//             A free-running divider produces a one-cycle clock-enable tick
//             every DIV_RATIO cycles; when counter_on is high on a tick, the
//             BCD value steps up or down. At the terminal value it either
//             wraps to the opposite extreme (pulsing wrap) or saturates.
//             Each digit is also decoded to active-high segments.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DIGITS     number of BCD digits (>=1), count width = 4*DIGITS
//    DIV_RATIO  clk cycles per count tick (>=1, 1 = tick every cycle)
//    WRAP       1 = wrap at terminal value, 0 = saturate
//  Ports
//    clk         in   system clock, rising-edge
//    reset       in   synchronous active-high reset
//    count_up    in   1 = increment, 0 = decrement
//    load        in   load clamped data_in on next edge, clears divider
//    counter_on  in   count enable, only meaningful on tick cycles
//    data_in     in   BCD load value, digit i at [4i+3:4i]
//    count       out  current BCD value
//    TC          out  terminal-count level (gated by counter_on)
//    wrap        out  one-cycle registered pulse on wrap-around
//    seg         out  segments, digit i at [7i+6:7i] = {g,f,e,d,c,b,a}
//  Build option
//    LEADING_ZERO_BLANK_EN  when defined, blank zero digits above digit 0
//                           while every digit above them is also zero
// ============================================================================
module multi_digit_bcd_counter #(
  parameter int DIGITS    = 4,
  parameter int DIV_RATIO = 50000000,
  parameter int WRAP      = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  count_up,
  input  logic                  load,
  input  logic                  counter_on,
  input  logic [4*DIGITS-1:0]   data_in,
  output logic [4*DIGITS-1:0]   count,
  output logic                  TC,
  output logic                  wrap,
  output logic [7*DIGITS-1:0]   seg
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int              DIV_W    = (DIV_RATIO > 1) ? $clog2(DIV_RATIO) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_RATIO - 1);
  localparam logic            WRAP_EN  = (WRAP != 0);

  // --------------------------------------------------------------------------
  // Tick divider
  //   Runs regardless of counter_on so the tick cadence does not drift when
  //   counting is paused. Load restarts the cadence so the first tick after a
  //   load lands exactly DIV_RATIO cycles later.
  // --------------------------------------------------------------------------
  logic [DIV_W-1:0] div_q;
  logic             tick;

  assign tick = (div_q == DIV_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= '0;
    end else if (load) begin
      div_q <= '0;
    end else if (tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Per-digit arithmetic
  //   carry[i]  : every digit below i is 9, so an increment reaches digit i
  //   borrow[i] : every digit below i is 0, so a decrement reaches digit i
  //   carry[DIGITS] / borrow[DIGITS] therefore double as the all-9s /
  //   all-0s detectors for the terminal-count logic.
  // --------------------------------------------------------------------------
  logic [DIGITS:0]       carry;
  logic [DIGITS:0]       borrow;
  logic [4*DIGITS-1:0]   inc_val;
  logic [4*DIGITS-1:0]   dec_val;
  logic [4*DIGITS-1:0]   load_val;
  logic [4*DIGITS-1:0]   all_nines;

  assign carry[0]  = 1'b1;
  assign borrow[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    logic [3:0] cur;
    logic [3:0] din;
    logic       is_nine;
    logic       is_zero;

    assign cur     = count[4*i +: 4];
    assign din     = data_in[4*i +: 4];
    assign is_nine = (cur == 4'd9);
    assign is_zero = (cur == 4'd0);

    assign carry[i+1]  = carry[i]  & is_nine;
    assign borrow[i+1] = borrow[i] & is_zero;

    assign inc_val[4*i +: 4] = !carry[i]  ? cur :
                               is_nine    ? 4'd0 : cur + 4'd1;
    assign dec_val[4*i +: 4] = !borrow[i] ? cur :
                               is_zero    ? 4'd9 : cur - 4'd1;

    // Non-BCD load digits (A..F) are clamped so count is always valid BCD.
    assign load_val[4*i +: 4]  = (din > 4'd9) ? 4'd9 : din;
    assign all_nines[4*i +: 4] = 4'd9;
  end : g_digit

  // --------------------------------------------------------------------------
  // Terminal count and next-value selection
  // --------------------------------------------------------------------------
  logic                at_term;
  logic                step;
  logic [4*DIGITS-1:0] count_next;
  logic                wrap_next;

  assign at_term = count_up ? carry[DIGITS] : borrow[DIGITS];
  assign TC      = counter_on & at_term;
  assign step    = tick & counter_on;

  always_comb begin
    count_next = count;
    wrap_next  = 1'b0;
    if (step) begin
      if (at_term) begin
        if (WRAP_EN) begin
          count_next = count_up ? '0 : all_nines;
          wrap_next  = 1'b1;
        end
        // Saturating mode: hold the terminal value, no wrap pulse.
      end else begin
        count_next = count_up ? inc_val : dec_val;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Count and wrap registers: reset > load > step > hold
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      wrap  <= 1'b0;
    end else if (load) begin
      count <= load_val;
      wrap  <= 1'b0;
    end else begin
      count <= count_next;
      wrap  <= wrap_next;
    end
  end

  // --------------------------------------------------------------------------
  // Seven-segment decode, {g,f,e,d,c,b,a}, active high
  // --------------------------------------------------------------------------
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00; // unreachable: count is always clamped BCD
    endcase
    return s;
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  // upper_zero[i]: digit i and every digit above it are zero, so digit i is
  // a leading zero. Built from the most significant digit downward.
  logic [DIGITS:1] upper_zero;

  assign upper_zero[DIGITS] = 1'b1 & (count[4*(DIGITS-1) +: 4] == 4'd0 || DIGITS == 1);

  for (genvar i = 0; i < DIGITS; i++) begin : g_seg
    if (i == 0) begin : g_lsd
      // The least significant digit always shows, so zero reads "0".
      assign seg[6:0] = seg_decode(count[3:0]);
    end else begin : g_upper
      if (i < DIGITS - 1) begin : g_chain
        assign upper_zero[i] = upper_zero[i+1] & (count[4*i +: 4] == 4'd0);
      end else begin : g_top
        assign upper_zero[i] = (count[4*i +: 4] == 4'd0);
      end
      assign seg[7*i +: 7] = upper_zero[i] ? 7'h00 : seg_decode(count[4*i +: 4]);
    end
  end : g_seg
`else
  for (genvar i = 0; i < DIGITS; i++) begin : g_seg
    assign seg[7*i +: 7] = seg_decode(count[4*i +: 4]);
  end : g_seg
`endif

endmodule : multi_digit_bcd_counter
`default_nettype wire

// File: tb/tb_multi_digit_bcd_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multi_digit_bcd_counter
//  Purpose  : Self-checking bench for multi_digit_bcd_counter. Two instances
//             with different shapes run side by side from shared controls:
//               A: 3 digits, tick every 4 cycles, wrapping
//               B: 2 digits, tick every cycle, saturating
//             A decimal-integer reference model predicts count, TC, wrap
//             and seg for each instance after every clock edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_multi_digit_bcd_counter;

  localparam int DA = 3;
  localparam int RA = 4;
  localparam int WA = 1;
  localparam int DB = 2;
  localparam int RB = 1;
  localparam int WB = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              count_up;
  logic              load;
  logic              counter_on;
  logic [4*DA-1:0]   din_a;
  logic [4*DB-1:0]   din_b;
  logic [4*DA-1:0]   count_a;
  logic [4*DB-1:0]   count_b;
  logic [7*DA-1:0]   seg_a;
  logic [7*DB-1:0]   seg_b;
  logic              tc_a, tc_b, wrap_a, wrap_b;

  multi_digit_bcd_counter #(.DIGITS(DA), .DIV_RATIO(RA), .WRAP(WA)) dut_a (
    .clk(clk), .reset(reset), .count_up(count_up), .load(load),
    .counter_on(counter_on), .data_in(din_a), .count(count_a),
    .TC(tc_a), .wrap(wrap_a), .seg(seg_a)
  );

  multi_digit_bcd_counter #(.DIGITS(DB), .DIV_RATIO(RB), .WRAP(WB)) dut_b (
    .clk(clk), .reset(reset), .count_up(count_up), .load(load),
    .counter_on(counter_on), .data_in(din_b), .count(count_b),
    .TC(tc_b), .wrap(wrap_b), .seg(seg_b)
  );

  // --------------------------------------------------------------------------
  // Reference model: value held as a plain decimal integer
  // --------------------------------------------------------------------------
  int m_val [2];
  int m_div [2];
  bit m_wrap[2];
  int n_cmp = 0;
  int n_err = 0;

  function automatic int pow10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic int clamp_load(input logic [31:0] din, input int nd);
    int v = 0;
    for (int i = 0; i < nd; i++) begin
      int nib = int'(din[4*i +: 4]);
      v = v + ((nib > 9) ? 9 : nib) * pow10(i);
    end
    return v;
  endfunction

  function automatic logic [31:0] to_bcd(input int v, input int nd);
    logic [31:0] r = '0;
    for (int i = 0; i < nd; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
    return r;
  endfunction

  function automatic logic [31:0] to_seg(input int v, input int nd);
    logic [6:0]  tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                              7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    logic [31:0] r = '0;
    for (int i = 0; i < nd; i++) begin
      logic [6:0] s = tab[(v / pow10(i)) % 10];
`ifdef LEADING_ZERO_BLANK_EN
      // digit i and all above it are zero exactly when v < 10^i
      if (i >= 1 && v < pow10(i)) s = 7'h00;
`endif
      r[7*i +: 7] = s;
    end
    return r;
  endfunction

  task automatic model_step(input int k, input int nd, input int ratio,
                            input int wmode, input logic [31:0] din);
    int top = pow10(nd) - 1;
    if (reset) begin
      m_val[k] = 0; m_div[k] = 0; m_wrap[k] = 0;
    end else if (load) begin
      m_val[k] = clamp_load(din, nd); m_div[k] = 0; m_wrap[k] = 0;
    end else begin
      bit tk = (m_div[k] == ratio - 1);
      m_div[k]  = tk ? 0 : m_div[k] + 1;
      m_wrap[k] = 0;
      if (tk && counter_on) begin
        if (count_up) begin
          if (m_val[k] < top)   m_val[k] = m_val[k] + 1;
          else if (wmode != 0)  begin m_val[k] = 0; m_wrap[k] = 1; end
        end else begin
          if (m_val[k] > 0)     m_val[k] = m_val[k] - 1;
          else if (wmode != 0)  begin m_val[k] = top; m_wrap[k] = 1; end
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic exp_tc(input int v, input int nd);
    return counter_on & (count_up ? (v == pow10(nd) - 1) : (v == 0));
  endfunction

  task automatic check_all();
    check("count_a", 32'(count_a), to_bcd(m_val[0], DA));
    check("tc_a",    32'(tc_a),    32'(exp_tc(m_val[0], DA)));
    check("wrap_a",  32'(wrap_a),  32'(m_wrap[0]));
    check("seg_a",   32'(seg_a),   to_seg(m_val[0], DA));
    check("count_b", 32'(count_b), to_bcd(m_val[1], DB));
    check("tc_b",    32'(tc_b),    32'(exp_tc(m_val[1], DB)));
    check("wrap_b",  32'(wrap_b),  32'(m_wrap[1]));
    check("seg_b",   32'(seg_b),   to_seg(m_val[1], DB));
  endtask

  // One clock edge: advance model with the inputs in force, check #1 later.
  task automatic edge_and_check();
    @(posedge clk);
    model_step(0, DA, RA, WA, 32'(din_a));
    model_step(1, DB, RB, WB, 32'(din_b));
    #1;
    check_all();
  endtask

  task automatic pick_din();
    case ($urandom_range(0, 2))
      0: begin din_a = 12'($urandom); din_b = 8'($urandom); end
      1: begin din_a = {8'h99, 4'($urandom)}; din_b = {4'h9, 4'($urandom)}; end
      default: begin din_a = {8'h00, 4'($urandom)}; din_b = {4'h0, 4'($urandom)}; end
    endcase
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; counter_on = 1'b0; count_up = 1'b1;
    din_a = '0; din_b = '0;
    m_val = '{0, 0}; m_div = '{0, 0}; m_wrap = '{0, 0};
    @(negedge clk);
    edge_and_check();                       // reset state

    // Count up through full range of B (and partway on A), across wrap/saturate
    reset = 1'b0; counter_on = 1'b1; count_up = 1'b1;
    for (int i = 0; i < 105; i++) edge_and_check();

    // Count down from a loaded zero, then through terminal
    load = 1'b1; din_a = 12'h000; din_b = 8'h00;
    edge_and_check();
    load = 1'b0; count_up = 1'b0;
    for (int i = 0; i < 10; i++) edge_and_check();

    // Load near top, count up into saturation / wrap
    load = 1'b1; din_a = 12'h998; din_b = 8'h98;
    edge_and_check();
    load = 1'b0; count_up = 1'b1;
    for (int i = 0; i < 12; i++) edge_and_check();

    // Non-BCD load digits clamp; reset beats a simultaneous load
    load = 1'b1; din_a = 12'hAB3; din_b = 8'hA3;
    edge_and_check();
    reset = 1'b1;
    edge_and_check();
    reset = 1'b0; load = 1'b0;

    // Paused counting: divider runs, count holds, TC low
    counter_on = 1'b0;
    for (int i = 0; i < 6; i++) edge_and_check();
    counter_on = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 199) == 0);
      load       = ($urandom_range(0, 19) == 0);
      counter_on = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 29) == 0) count_up = ~count_up;
      pick_din();
      edge_and_check();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_multi_digit_bcd_counter
`default_nettype wire
